fa_bist_ctrl: RTL and testbench

//  On-chip exhaustive self-test controller for the 1-bit full adder `fa`.
//  - Stimulus: drives the 8 input vectors {a,b,cin} = 000..111 into the adder.
//  - Check: compares sum/cout against a golden model and reports pass/fail and error data.
//  - Placement: sits beside the adder as its stimulus/response end and replaces the simulation-only bench in silicon.

---
 rtl/fa_bist_pkg.sv | 26 ++
 rtl/fa_bist_ctrl_golden.sv | 17 +
 rtl/fa_bist_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fa_bist_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fa_bist_pkg.sv
// Shared types and helpers for the full-adder BIST controller.
//   state_e        : controller FSM states
//   VEC_W/VEC_LAST : width of the {a,b,cin} stimulus vector and its final value
//   exp_sum/cout   : golden full-adder equations used by the reference adder
package fa_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int VEC_W = 3;
  localparam logic [VEC_W-1:0] VEC_LAST = 3'b111;

  // Vector layout is {a, b, cin}.
  function automatic logic exp_sum(input logic [VEC_W-1:0] vec);
    return ^vec;
  endfunction

  function automatic logic exp_cout(input logic [VEC_W-1:0] vec);
    return (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
  endfunction

endpackage

// File: rtl/fa_bist_ctrl_golden.sv
// Combinational reference full adder used as the golden model for the BIST
// compare.
//   vec_i  : {a, b, cin} currently applied to the adder under test
//   sum_o  : expected sum
//   cout_o : expected carry-out
module fa_golden
  import fa_bist_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic             sum_o,
  output logic             cout_o
);

  assign sum_o  = exp_sum(vec_i);
  assign cout_o = exp_cout(vec_i);

endmodule

// File: rtl/fa_bist_ctrl.sv
// Exhaustive self-test controller for a 1-bit full adder. Sweeps {a,b,cin}
// through 000..111 (NUM_PASSES times), holds each vector SETTLE_CYCLES cycles,
// then compares the adder's sum/cout against a golden adder for one cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : one-cycle run request, honoured only in IDLE
//   dut_sum, dut_cout   : responses from the adder under test
//   dut_a, dut_b, dut_cin : registered stimulus to the adder (vec[2], vec[1], vec[0])
//   busy                : run in progress (SETTLE, CHECK or DONE)
//   done                : one-cycle pulse at the end of a run
//   pass                : last run had no mismatches; held until next start
//   err_count           : saturating mismatch count
//   err_vec, err_valid  : first failing vector and its qualifier
module fa_bist_ctrl
  import fa_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dut_sum,
  input  logic             dut_cout,
  output logic             dut_a,
  output logic             dut_b,
  output logic             dut_cin,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] err_vec,
  output logic             err_valid
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PAS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [PAS_W-1:0] PASS_LAST   = PAS_W'(NUM_PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [PAS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;
  logic [VEC_W-1:0]   err_vec_q, err_vec_d;
  logic               err_valid_q, err_valid_d;
  logic               pass_q, pass_d;

  logic gold_sum, gold_cout;
  logic mismatch;

  fa_golden u_golden (
    .vec_i  (vec_q),
    .sum_o  (gold_sum),
    .cout_o (gold_cout)
  );

  assign mismatch = (dut_sum != gold_sum) || (dut_cout != gold_cout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      pass_cnt_q   <= '0;
      settle_cnt_q <= '0;
      err_count_q  <= '0;
      err_vec_q    <= '0;
      err_valid_q  <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      pass_cnt_q   <= pass_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_count_q  <= err_count_d;
      err_vec_q    <= err_vec_d;
      err_valid_q  <= err_valid_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    pass_cnt_d   = pass_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_count_d  = err_count_q;
    err_vec_d    = err_vec_q;
    err_valid_d  = err_valid_q;
    pass_d       = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          vec_d        = '0;
          pass_cnt_d   = '0;
          settle_cnt_d = '0;
          err_count_d  = '0;
          err_vec_d    = '0;
          err_valid_d  = 1'b0;
          pass_d       = 1'b0;
          state_d      = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (!err_valid_q) begin
            err_vec_d   = vec_q;
            err_valid_d = 1'b1;
          end
        end
        if (vec_q != VEC_LAST) begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_SETTLE;
        end else if (pass_cnt_q != PASS_LAST) begin
          vec_d      = '0;
          pass_cnt_d = pass_cnt_q + 1'b1;
          state_d    = ST_SETTLE;
        end else begin
          // Resolve pass on entry to DONE from the post-compare count so it
          // already reflects the final vector and is valid alongside done.
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        vec_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign dut_a     = vec_q[2];
  assign dut_b     = vec_q[1];
  assign dut_cin   = vec_q[0];
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign err_vec   = err_vec_q;
  assign err_valid = err_valid_q;

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Bench for fa_bist_ctrl: three controller instances (defaults, three passes,
// three settle cycles with a two-cycle-latency adder) driven by a fault-table
// adder model; expected results come from a vector-count reference model.
module tb_fa_bist_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_r [3];
  logic       a_w [3], b_w [3], cin_w [3];
  logic       busy_w [3], done_w [3], pass_w [3], errval_w [3];
  logic [3:0] errc_w [3];
  logic [2:0] errv_w [3];

  logic sum0, cout0, sum1, cout1, sum2, cout2;
  logic [7:0] sum_flip, cout_flip;
  logic [1:0] dly1, dly2;

  int done_cnt [3];
  int n_checks = 0;
  int n_errors = 0;

  // Faulty adder: arithmetic full adder with per-vector output inversions.
  function automatic logic [1:0] fa_model(input logic [2:0] v, input logic [7:0] sf,
                                          input logic [7:0] cf);
    int  ones;
    logic s, c;
    ones = int'(v[0]) + int'(v[1]) + int'(v[2]);
    s = ((ones % 2) == 1) ^ sf[v];
    c = (ones >= 2) ^ cf[v];
    return {c, s};
  endfunction

  assign {cout0, sum0} = fa_model({a_w[0], b_w[0], cin_w[0]}, sum_flip, cout_flip);
  assign {cout1, sum1} = fa_model({a_w[1], b_w[1], cin_w[1]}, sum_flip, cout_flip);

  always @(posedge clk) begin
    dly1 <= fa_model({a_w[2], b_w[2], cin_w[2]}, sum_flip, cout_flip);
    dly2 <= dly1;
  end
  assign {cout2, sum2} = dly2;

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .dut_sum(sum0), .dut_cout(cout0),
    .dut_a(a_w[0]), .dut_b(b_w[0]), .dut_cin(cin_w[0]), .busy(busy_w[0]),
    .done(done_w[0]), .pass(pass_w[0]), .err_count(errc_w[0]), .err_vec(errv_w[0]),
    .err_valid(errval_w[0])
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(1), .NUM_PASSES(3), .ERR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .dut_sum(sum1), .dut_cout(cout1),
    .dut_a(a_w[1]), .dut_b(b_w[1]), .dut_cin(cin_w[1]), .busy(busy_w[1]),
    .done(done_w[1]), .pass(pass_w[1]), .err_count(errc_w[1]), .err_vec(errv_w[1]),
    .err_valid(errval_w[1])
  );

  fa_bist_ctrl #(.SETTLE_CYCLES(3), .NUM_PASSES(1), .ERR_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .dut_sum(sum2), .dut_cout(cout2),
    .dut_a(a_w[2]), .dut_b(b_w[2]), .dut_cin(cin_w[2]), .busy(busy_w[2]),
    .done(done_w[2]), .pass(pass_w[2]), .err_count(errc_w[2]), .err_vec(errv_w[2]),
    .err_valid(errval_w[2])
  );

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) done_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pins(input int sel);
    return {29'd0, a_w[sel], b_w[sel], cin_w[sel]};
  endfunction

  // One complete run on instance sel. extra1/extra2 are cycles in which start
  // is pulsed again (ignored by the controller); -1 picks a random one.
  task automatic run(input int sel, input int passes, input int settle,
                     input int extra1, input int extra2, input string tag);
    int nfail, first, exp_cnt, exp_done, done_at, base, vec_bad, cyc, x1;
    nfail = 0; first = -1; done_at = -1; vec_bad = 0;
    for (int v = 0; v < 8; v++) begin
      if (sum_flip[v] | cout_flip[v]) begin
        nfail++;
        if (first < 0) first = v;
      end
    end
    exp_cnt  = (passes * nfail > 15) ? 15 : passes * nfail;
    exp_done = 1 + passes * 8 * (settle + 1);
    x1 = (extra1 < 0) ? int'($urandom_range(2, exp_done)) : extra1;
    base = done_cnt[sel];

    @(posedge clk); #1 start_r[sel] = 1'b1;
    @(posedge clk); #1 start_r[sel] = 1'b0;
    cyc = 1;
    chk({tag, ".busy_start"}, int'(busy_w[sel]), 1);
    while (cyc <= exp_done + 4) begin
      if (done_w[sel] && done_at < 0) begin
        done_at = cyc;
        chk({tag, ".vec_at_done"}, pins(sel), 7);
        chk({tag, ".pass_at_done"}, int'(pass_w[sel]), (nfail == 0) ? 1 : 0);
        chk({tag, ".err_count"}, int'(errc_w[sel]), exp_cnt);
        chk({tag, ".err_valid"}, int'(errval_w[sel]), (nfail > 0) ? 1 : 0);
        chk({tag, ".err_vec"}, int'(errv_w[sel]), (nfail > 0) ? first : 0);
      end else if (done_at < 0) begin
        if (pins(sel) != ((cyc - 1) / (settle + 1)) % 8) vec_bad++;
      end
      start_r[sel] = (cyc == x1 || cyc == extra2);
      @(posedge clk); #1 cyc++;
    end
    start_r[sel] = 1'b0;
    chk({tag, ".done_cycle"}, done_at, exp_done);
    chk({tag, ".done_pulses"}, done_cnt[sel] - base, 1);
    chk({tag, ".vec_sequence_errs"}, vec_bad, 0);
    chk({tag, ".busy_after"}, int'(busy_w[sel]), 0);
    chk({tag, ".vec_after"}, pins(sel), 0);
    chk({tag, ".pass_held"}, int'(pass_w[sel]), (nfail == 0) ? 1 : 0);
    chk({tag, ".err_count_held"}, int'(errc_w[sel]), exp_cnt);
  endtask

  initial begin
    int base, sel;
    rst_n = 1'b0;
    sum_flip = 8'h00;
    cout_flip = 8'h00;
    for (int i = 0; i < 3; i++) start_r[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy_w[0]), 0);
    chk("reset.pins", pins(0), 0);
    chk("reset.pass", int'(pass_w[0]), 0);
    chk("reset.err_count", int'(errc_w[0]), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle.done", int'(done_w[0]), 0);

    // Good adder, defaults.
    run(0, 1, 1, 0, 0, "good");
    // cout stuck-at-0: fails at 011, 101, 110, 111.
    cout_flip = 8'hE8;
    run(0, 1, 1, 0, 0, "cout_sa0");
    // Sum inverted over three passes: saturating count.
    cout_flip = 8'h00;
    sum_flip = 8'hFF;
    run(1, 3, 1, 0, 0, "sum_inv_x3");
    // Re-pulsed start mid-run and in the DONE cycle.
    sum_flip = 8'h00;
    run(0, 1, 1, 5, 17, "restart");
    // Slow adder with longer settle.
    run(2, 1, 3, 0, 0, "slow_adder");

    // Reset mid-run aborts with no done pulse.
    sum_flip = 8'hFF;
    base = done_cnt[0];
    @(posedge clk); #1 start_r[0] = 1'b1;
    @(posedge clk); #1 start_r[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort.busy", int'(busy_w[0]), 0);
    chk("abort.pins", pins(0), 0);
    chk("abort.err_count", int'(errc_w[0]), 0);
    chk("abort.done", int'(done_w[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("abort.no_done", done_cnt[0] - base, 0);
    chk("abort.still_idle", int'(busy_w[0]), 0);
    sum_flip = 8'h00;
    run(0, 1, 1, 0, 0, "after_abort");

    // Randomized runs across all three configurations.
    for (int it = 0; it < 24; it++) begin
      sel = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) begin
        sum_flip  = 8'h00;
        cout_flip = 8'h00;
      end else begin
        sum_flip  = 8'($urandom & $urandom);
        cout_flip = 8'($urandom & $urandom);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      case (sel)
        0:       run(0, 1, 1, -1, 0, "rand_d0");
        1:       run(1, 3, 1, -1, 0, "rand_d1");
        default: run(2, 1, 3, -1, 0, "rand_d2");
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
